// File: rtl/demux2_stage_if.sv
// demux2_stage_if: valid/ready bundle for the 1-to-2 steering stage.
// One input stream (in_*) and two output streams (out0_*, out1_*).
// The stage side uses modport slave; the producer/consumer side uses modport master.
interface demux2_stage_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic             in_sel;
    logic [WIDTH-1:0] in_data;

    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out0_data;

    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;

    // Stage view: consumes the input stream and produces both output streams.
    modport slave (
        input  in_valid,
        output in_ready,
        input  in_sel,
        input  in_data,
        output out0_valid,
        input  out0_ready,
        output out0_data,
        output out1_valid,
        input  out1_ready,
        output out1_data
    );

    // Environment view: produces the input stream and consumes both outputs.
    modport master (
        output in_valid,
        input  in_ready,
        output in_sel,
        output in_data,
        input  out0_valid,
        output out0_ready,
        input  out0_data,
        input  out1_valid,
        output out1_ready,
        input  out1_data
    );
endinterface

// File: rtl/demux2_stage.sv
// demux2_stage: registered 1-to-2 steering stage.
// Each beat goes, by in_sel, to one of two outputs. Each output owns a
// one-entry holding register, so a stalled output never blocks the other one.
// Optional transfer counters cnt0/cnt1 are built when DEMUX2_STAGE_COUNT_EN
// is defined.
module demux2_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    demux2_stage_if.slave       bus
`ifdef DEMUX2_STAGE_COUNT_EN
    ,
    output logic [31:0]         cnt0,
    output logic [31:0]         cnt1
`endif
);
    localparam int unsigned CNT_W = 32;

    logic             out0_valid_q, out0_valid_d;
    logic             out1_valid_q, out1_valid_d;
    logic [WIDTH-1:0] out0_data_q,  out0_data_d;
    logic [WIDTH-1:0] out1_data_q,  out1_data_d;

    logic slot0_rdy, slot1_rdy;
    logic drain0, drain1;
    logic load0, load1;

    // Slot readiness, drain and load qualifiers; in_valid gates in_sel so an
    // undriven select on an idle cycle cannot reach the registers.
    always_comb begin
        slot0_rdy = ~out0_valid_q | bus.out0_ready;
        slot1_rdy = ~out1_valid_q | bus.out1_ready;
        drain0    = out0_valid_q & bus.out0_ready;
        drain1    = out1_valid_q & bus.out1_ready;
        load0     = bus.in_valid & reset_n & ~bus.in_sel & slot0_rdy;
        load1     = bus.in_valid & reset_n &  bus.in_sel & slot1_rdy;
    end

    // Next-state for both holding registers: reload wins over drain.
    always_comb begin
        out0_valid_d = out0_valid_q;
        out1_valid_d = out1_valid_q;
        out0_data_d  = out0_data_q;
        out1_data_d  = out1_data_q;
        if (drain0) out0_valid_d = 1'b0;
        if (drain1) out1_valid_d = 1'b0;
        if (load0) begin
            out0_valid_d = 1'b1;
            out0_data_d  = bus.in_data;
        end
        if (load1) begin
            out1_valid_d = 1'b1;
            out1_data_d  = bus.in_data;
        end
    end

    // Holding registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out0_valid_q <= 1'b0;
            out1_valid_q <= 1'b0;
            out0_data_q  <= '0;
            out1_data_q  <= '0;
        end else begin
            out0_valid_q <= out0_valid_d;
            out1_valid_q <= out1_valid_d;
            out0_data_q  <= out0_data_d;
            out1_data_q  <= out1_data_d;
        end
    end

    // Ready is combinational on in_sel and the selected consumer ready.
    assign bus.in_ready   = reset_n & (bus.in_sel ? slot1_rdy : slot0_rdy);
    assign bus.out0_valid = out0_valid_q;
    assign bus.out1_valid = out1_valid_q;
    assign bus.out0_data  = out0_data_q;
    assign bus.out1_data  = out1_data_q;

`ifdef DEMUX2_STAGE_COUNT_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    // Transfer counters wrap naturally modulo 2^32.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (drain0) cnt0_d = cnt0_q + CNT_W'(1);
        if (drain1) cnt1_d = cnt1_q + CNT_W'(1);
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`endif
endmodule

// File: tb/tb_demux2_stage.sv
// tb_demux2_stage: directed bench for demux2_stage.
// Inputs change on the falling edge; outputs are checked on the falling edge
// (registered values) or 1 time unit after driving (combinational in_ready).
module tb_demux2_stage;
    localparam int unsigned WIDTH = 32;

    logic clk;
    logic reset_n;
    int   checks;
    int   passes;

    demux2_stage_if #(.WIDTH(WIDTH)) bus ();

`ifdef DEMUX2_STAGE_COUNT_EN
    logic [31:0] cnt0;
    logic [31:0] cnt1;
    demux2_stage #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .cnt0    (cnt0),
        .cnt1    (cnt1)
    );
`else
    demux2_stage #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic s, input logic [31:0] d);
        bus.in_valid = v;
        bus.in_sel   = s;
        bus.in_data  = d;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        bus.out0_ready = 1'b1;
        bus.out1_ready = 1'b1;
        cyc();
        cyc();
        checks++; if (bus.out0_valid !== 1'b0) $display("FAIL rst_out0_valid got %b exp 0", bus.out0_valid); else passes++;
        checks++; if (bus.out1_valid !== 1'b0) $display("FAIL rst_out1_valid got %b exp 0", bus.out1_valid); else passes++;
        checks++; if (bus.in_ready !== 1'b0) $display("FAIL rst_in_ready got %b exp 0", bus.in_ready); else passes++;
        checks++; if (bus.out0_data !== 32'h0) $display("FAIL rst_out0_data got %h exp 0", bus.out0_data); else passes++;
        checks++; if (bus.out1_data !== 32'h0) $display("FAIL rst_out1_data got %h exp 0", bus.out1_data); else passes++;
        reset_n = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL idle_in_ready got %b exp 1", bus.in_ready); else passes++;
        cyc();
    endtask

    task automatic test_basic_steering();
        drive(1'b1, 1'b0, 32'hAAAA0001);
        #1;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL basic_in_ready0 got %b exp 1", bus.in_ready); else passes++;
        cyc();
        checks++; if (bus.out0_valid !== 1'b1 || bus.out0_data !== 32'hAAAA0001)
            $display("FAIL basic_out0 got v=%b d=%h exp v=1 d=aaaa0001", bus.out0_valid, bus.out0_data); else passes++;
        checks++; if (bus.out1_valid !== 1'b0) $display("FAIL basic_out1_idle got %b exp 0", bus.out1_valid); else passes++;
        drive(1'b1, 1'b1, 32'hBBBB0002);
        cyc();
        checks++; if (bus.out1_valid !== 1'b1 || bus.out1_data !== 32'hBBBB0002)
            $display("FAIL basic_out1 got v=%b d=%h exp v=1 d=bbbb0002", bus.out1_valid, bus.out1_data); else passes++;
        checks++; if (bus.out0_valid !== 1'b0) $display("FAIL basic_out0_dup got %b exp 0", bus.out0_valid); else passes++;
        drive(1'b0, 1'bx, 32'h0);
        cyc();
        checks++; if (bus.out1_valid !== 1'b0) $display("FAIL basic_out1_dup got %b exp 0", bus.out1_valid); else passes++;
        checks++; if (bus.out0_valid !== 1'b0) $display("FAIL xsel_out0_valid got %b exp 0", bus.out0_valid); else passes++;
    endtask

    task automatic test_backpressure();
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b1;
        drive(1'b1, 1'b0, 32'h00000011);
        cyc();
        drive(1'b1, 1'b0, 32'h00000022);
        #1;
        checks++; if (bus.in_ready !== 1'b0) $display("FAIL bp_stall_ready got %b exp 0", bus.in_ready); else passes++;
        cyc();
        checks++; if (bus.out0_valid !== 1'b1 || bus.out0_data !== 32'h00000011)
            $display("FAIL bp_hold got v=%b d=%h exp v=1 d=00000011", bus.out0_valid, bus.out0_data); else passes++;
        checks++; if (bus.out1_valid !== 1'b0) $display("FAIL bp_out1_early got %b exp 0", bus.out1_valid); else passes++;
        bus.out0_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL bp_reload_ready got %b exp 1", bus.in_ready); else passes++;
        cyc();
        checks++; if (bus.out0_valid !== 1'b1 || bus.out0_data !== 32'h00000022)
            $display("FAIL bp_second got v=%b d=%h exp v=1 d=00000022", bus.out0_valid, bus.out0_data); else passes++;
        drive(1'b1, 1'b1, 32'h12345678);
        cyc();
        checks++; if (bus.out1_valid !== 1'b1 || bus.out1_data !== 32'h12345678)
            $display("FAIL bp_out1 got v=%b d=%h exp v=1 d=12345678", bus.out1_valid, bus.out1_data); else passes++;
        checks++; if (bus.out0_valid !== 1'b0) $display("FAIL bp_out0_drained got %b exp 0", bus.out0_valid); else passes++;
        drive(1'b0, 1'b0, 32'h0);
        cyc();
    endtask

    task automatic test_back_to_back();
        bus.out1_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 1'b1, 32'(i));
            #1;
            checks++; if (bus.in_ready !== 1'b1) $display("FAIL b2b_ready_%0d got %b exp 1", i, bus.in_ready); else passes++;
            if (i > 1) begin
                checks++; if (bus.out1_valid !== 1'b1 || bus.out1_data !== 32'(i - 1))
                    $display("FAIL b2b_data_%0d got v=%b d=%h exp v=1 d=%h", i - 1, bus.out1_valid, bus.out1_data, 32'(i - 1)); else passes++;
            end
            cyc();
        end
        drive(1'b0, 1'b0, 32'h0);
        checks++; if (bus.out1_valid !== 1'b1 || bus.out1_data !== 32'd8)
            $display("FAIL b2b_data_8 got v=%b d=%h exp v=1 d=8", bus.out1_valid, bus.out1_data); else passes++;
        cyc();
    endtask

    task automatic test_reset_mid();
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        drive(1'b1, 1'b0, 32'h000000A0);
        cyc();
        drive(1'b1, 1'b1, 32'h000000B0);
        cyc();
        drive(1'b0, 1'b0, 32'h0);
        checks++; if (bus.out0_valid !== 1'b1 || bus.out1_valid !== 1'b1)
            $display("FAIL mid_full got v0=%b v1=%b exp 1 1", bus.out0_valid, bus.out1_valid); else passes++;
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        checks++; if (bus.out0_valid !== 1'b0 || bus.out1_valid !== 1'b0)
            $display("FAIL mid_cleared got v0=%b v1=%b exp 0 0", bus.out0_valid, bus.out1_valid); else passes++;
        bus.out0_ready = 1'b1;
        bus.out1_ready = 1'b1;
        cyc();
        checks++; if (bus.out0_valid !== 1'b0 || bus.out1_valid !== 1'b0)
            $display("FAIL mid_stale got v0=%b v1=%b exp 0 0", bus.out0_valid, bus.out1_valid); else passes++;
    endtask

`ifdef DEMUX2_STAGE_COUNT_EN
    task automatic test_counters();
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        checks++; if (cnt0 !== 32'd0 || cnt1 !== 32'd0)
            $display("FAIL cnt_reset got %h %h exp 0 0", cnt0, cnt1); else passes++;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 32'(i));
            cyc();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 32'(i));
            cyc();
        end
        drive(1'b0, 1'b0, 32'h0);
        cyc();
        cyc();
        checks++; if (cnt0 !== 32'd5) $display("FAIL cnt0 got %0d exp 5", cnt0); else passes++;
        checks++; if (cnt1 !== 32'd3) $display("FAIL cnt1 got %0d exp 3", cnt1); else passes++;
        force dut.cnt0_q = 32'hFFFFFFFF;
        #1;
        release dut.cnt0_q;
        drive(1'b1, 1'b0, 32'h55);
        cyc();
        drive(1'b0, 1'b0, 32'h0);
        cyc();
        checks++; if (cnt0 !== 32'd0) $display("FAIL cnt0_wrap got %h exp 0", cnt0); else passes++;
    endtask
`endif

    initial begin
        checks = 0;
        passes = 0;
        bus.in_valid   = 1'b0;
        bus.in_sel     = 1'b0;
        bus.in_data    = '0;
        bus.out0_ready = 1'b1;
        bus.out1_ready = 1'b1;
        reset_n        = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic_steering();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef DEMUX2_STAGE_COUNT_EN
        test_counters();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/demux2_stage.md
Name: demux2_stage

Overview:
- Registered 1-to-2 steering stage for the RISC-V pipeline.
- Takes one valid/ready stream and routes each beat, by a per-beat select bit, to exactly one of two valid/ready output streams. Example use: splitting writeback results between the register file path and the CSR/load-store path.
- Each output has its own one-entry holding register, so a stalled output does not block beats steered to the other output.
- Direction-inverse of the 2-input select used in the datapath.

Parameters:
- WIDTH, 32, data width in bits of the input and both outputs.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous, active-low reset
- in_valid  input  1  input beat present
- in_ready  output  1  stage accepts the input beat this cycle
- in_sel  input  1  destination of the beat: 0 = output 0, 1 = output 1
- in_data  input  WIDTH  input payload
- out0_valid  output  1  output 0 holds a beat
- out0_ready  input  1  consumer 0 takes the beat
- out0_data  output  WIDTH  output 0 payload
- out1_valid  output  1  output 1 holds a beat
- out1_ready  input  1  consumer 1 takes the beat
- out1_data  output  WIDTH  output 1 payload

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low; it is sampled on the rising edge of clk while reset_n = 0.
- Reset values:
  - out0_valid = 0, out1_valid = 0.
  - out0_data and out1_data = 0.
  - Optional counters = 0.
  - in_ready during reset is 0: it is gated by reset_n.
- Per-output holding register k (k = 0, 1):
  - State: EMPTY (outk_valid = 0) or FULL (outk_valid = 1).
  - outk_data is driven directly from the register; there is no combinational path from in_data.
- Drain: transfer on output k occurs when outk_valid & outk_ready at a rising edge.
- Readiness: slot k is ready when ~outk_valid | outk_ready.
  - in_ready = reset_n & (in_sel ? slot1 ready : slot0 ready).
  - in_ready depends on in_sel and on the selected outk_ready. This combinational ready path is intentional.
- Accept: input transfer when in_valid & in_ready. On that edge, register in_sel loads in_data and sets its valid.
- Latency: an accepted beat appears on its output the next cycle (1-cycle latency).
- Throughput: 1 beat/cycle per output when the consumer holds ready high.
- FULL and draining with a same-cycle accept to the same k:
  - The register reloads with the new data; valid stays 1.
  - No bubble and no loss.
- FULL and not draining: beats with in_sel = k are stalled (in_ready = 0). Beats to the other output still flow.
- Drain without accept on k: valid clears to 0; data may hold its old value.
- Simultaneous events are independent:
  - Output 0 and output 1 can both drain in the same cycle.
  - Drains on both outputs can coincide with one accept.
- Ordering across outputs is not preserved; ordering within each output is FIFO (depth 1).
- Producer rules:
  - Producer must keep in_data and in_sel stable while in_valid = 1 and in_ready = 0.
  - The stage does not check this rule.
- Consumer side: outk_valid and outk_data are stable while outk_valid = 1 and outk_ready = 0.
- Reset mid-operation: the next edge with reset_n = 0 discards any held beats. Valids clear and no transfer is reported that cycle.
- X-safety: when in_valid = 0, in_sel = X must not propagate into register state.

Optional Feature:
- Macro: DEMUX2_STAGE_COUNT_EN.
- Defined: adds output ports cnt0 and cnt1, each 32 bits wide.
  - cntk increments by 1 on every output-k transfer (outk_valid & outk_ready).
  - Counters wrap modulo 2^32 (0xFFFFFFFF -> 0).
  - Counters reset to 0 on reset_n = 0.
- Undefined: the ports and counter logic are absent. Steering behaviour is identical in both builds.

Test Plan:
- Reset then idle: hold reset_n = 0 for 2 cycles -> out0_valid = out1_valid = 0, in_ready = 0. After release, with both outputs ready and in_valid = 0 -> in_ready = 1.
- Basic steering: send 0xAAAA0001 with in_sel = 0, then 0xBBBB0002 with in_sel = 1, both consumers ready.
  - Required: out0 shows 0xAAAA0001 one cycle after its accept.
  - Required: out1 shows 0xBBBB0002 the following cycle.
  - Required: no duplicates.
- Independent backpressure: out0_ready = 0, send two beats with in_sel = 0 then 0x12345678 with in_sel = 1.
  - Required: first beat held in out0; in_ready = 0 for the second.
  - Required: 0x12345678 is delayed until the stalled second sel = 0 beat is accepted, then appears on out1 one cycle later.
  - Required: releasing out0_ready drains both sel = 0 beats in order.
- Full-throughput reload: out1_ready = 1, stream 8 consecutive sel = 1 beats 1..8 -> out1 presents 1..8 on 8 consecutive cycles and in_ready stays 1.
- Reset mid-operation: both outputs FULL with their readys low, pulse reset_n = 0 for 1 cycle -> both valids = 0 on the next cycle; no stale beat appears after reset_n returns to 1.
- With DEMUX2_STAGE_COUNT_EN: 5 transfers on out0 and 3 on out1 -> cnt0 = 5, cnt1 = 3. Preload cnt0 = 0xFFFFFFFF via force, then one transfer -> cnt0 = 0.
